reg_file_nr1w: RTL
==================

// Module: reg_file_nr1w
// PURPOSE
//  Parametrised register file for the Salamander-4 datapath: DEPTH x WIDTH storage, one write port, NRD read ports.
//  Reads are registered with 1-cycle latency and a per-port valid flag.
//  Write-first bypass: a read of the address written in the same cycle returns the new data.
//  Optional hardwired-zero register 0. Synchronous bulk clear.
// PARAMETERS
//  WIDTH     8   data width in bits (>=1)
//  DEPTH     4   number of registers (power of 2, >=2)
//  NRD       2   number of read ports (1..4)
//  ZERO_REG  0   1: register 0 always reads 0 and ignores writes
//  AW        $clog2(DEPTH)  address width (localparam, not overridable)
// PORTS
//  CLK      in   1          rising-edge clock
//  RSTN     in   1          asynchronous active-low reset
//  CLR      in   1          synchronous clear of all entries
//  WE       in   1          write enable
//  WADDR    in   AW         write address
//  WDATA    in   WIDTH      write data
//  RE       in   NRD        per-port read enable
//  RADDR    in   NRD*AW     read addresses; port p = RADDR[p*AW +: AW]
//  RDATA    out  NRD*WIDTH  read data; port p = RDATA[p*WIDTH +: WIDTH]
//  RVALID   out  NRD        RDATA[p] valid; high one cycle after RE[p]
// BEHAVIOUR
//  Reset (RSTN=0, async): all entries = 0; RDATA = 0; RVALID = 0. No X/Z is ever stored.
//  Write: at posedge CLK with WE=1 and CLR=0, mem[WADDR] <= WDATA.
//    Ignored when ZERO_REG=1 and WADDR=0.
//  Read port p: at posedge with RE[p]=1: RDATA[p] <= value; RVALID[p] <= 1.
//    With RE[p]=0: RDATA[p] holds its previous value; RVALID[p] <= 0.
//  Value selection, in priority order:
//    1. ZERO_REG=1 && RADDR[p]=0 -> 0
//    2. CLR=1 -> 0
//    3. WE=1 && WADDR==RADDR[p] -> WDATA (bypass)
//    4. otherwise mem[RADDR[p]]
//  Multiple read ports may target the same address in the same cycle; each gets an identical value.
//  CLR: at posedge, all entries <= 0; a simultaneous WE is dropped (CLR wins).
//  Out-of-range addresses cannot occur because DEPTH is a power of two.
//  Latency: write-to-read through storage = 1 cycle; same-cycle read of the write address uses the bypass.
//  Reset asserted mid-operation clears storage and outputs immediately; first valid read is one cycle after RE, following RSTN release.
// STRUCTURE
//  Shared package rf_pkg:
//    default WIDTH/DEPTH constants
//    typedef rf_addr_t = logic [AW-1:0]
//    function rf_rd_sel (implements the priority order above)
//  One sub-module rf_read_port, instantiated NRD times via a generate loop.
//    It holds the RDATA/RVALID registers and the bypass mux.
//    Storage and the write logic stay in the top level.
// TESTING
//  1. Reset: RSTN=0 mid-run -> all RDATA=0, RVALID=0; after release, read all addresses -> 0.
//  2. Write/read: WE, WADDR=2, WDATA=8'hA5; next cycle RE[0], RADDR0=2
//     -> one cycle later RDATA0=8'hA5, RVALID0=1.
//  3. Bypass: WE, WADDR=1, WDATA=8'h3C, with RE[1]=1, RADDR1=1 in the same cycle
//     -> next cycle RDATA1=8'h3C (not the old value).
//  4. Dual read: mem[3]=8'h11, mem[0]=8'h22; RE=2'b11, RADDR0=3, RADDR1=0
//     -> RDATA0=8'h11, RDATA1=8'h22 in the same cycle.
//  5. ZERO_REG=1: write 8'hFF to addr 0 -> reads of addr 0 return 0; bypass also returns 0.
//  6. CLR with WE=1, WADDR=2, WDATA=8'h77 -> all entries 0; a read of addr 2 returns 0.
//     RE=0 for one cycle -> RDATA holds its value, RVALID=0.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and read-value selection for the register file
package rf_pkg;

    localparam int RF_WIDTH = 8;
    localparam int RF_DEPTH = 4;
    localparam int RF_AW    = $clog2(RF_DEPTH);

    typedef logic [RF_AW-1:0] rf_addr_t;

    // Source of the value a read port captures
    typedef enum logic [1:0] {
        RF_SEL_ZERO  = 2'd0,
        RF_SEL_WDATA = 2'd1,
        RF_SEL_MEM   = 2'd2
    } rf_sel_e;

    // Hardwired zero beats clear, clear beats bypass, bypass beats storage
    function automatic rf_sel_e rf_rd_sel(input logic zero_hit,
                                          input logic clr,
                                          input logic bypass_hit);
        if (zero_hit)
            return RF_SEL_ZERO;
        else if (clr)
            return RF_SEL_ZERO;
        else if (bypass_hit)
            return RF_SEL_WDATA;
        else
            return RF_SEL_MEM;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one registered read port with write-first bypass
module rf_read_port
    import rf_pkg::*;
#(
    parameter int WIDTH    = RF_WIDTH,
    parameter int AW       = RF_AW,
    parameter int ZERO_REG = 0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CLR,
    input  logic             WE,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             RE,
    input  logic [AW-1:0]    RADDR,
    input  logic [WIDTH-1:0] MEM_DATA,
    output logic [WIDTH-1:0] RDATA,
    output logic             RVALID
);

    logic             zero_hit;
    logic             bypass_hit;
    rf_sel_e          sel;
    logic [WIDTH-1:0] rd_value;

    assign zero_hit   = (ZERO_REG != 0) && (RADDR == '0);
    assign bypass_hit = WE && (WADDR == RADDR);
    assign sel        = rf_rd_sel(zero_hit, CLR, bypass_hit);

    // Pick the value this port would capture at the coming edge
    always_comb begin
        rd_value = '0;
        case (sel)
            RF_SEL_ZERO:  rd_value = '0;
            RF_SEL_WDATA: rd_value = WDATA;
            RF_SEL_MEM:   rd_value = MEM_DATA;
            default:      rd_value = '0;
        endcase
    end

    // Capture on RE; data holds when idle while valid drops
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            RDATA  <= '0;
            RVALID <= 1'b0;
        end else begin
            RVALID <= RE;
            if (RE)
                RDATA <= rd_value;
        end
    end

endmodule

// File: rtl/reg_file_nr1w.sv
// rtl/reg_file_nr1w.sv - DEPTH x WIDTH register file, one write port, NRD read ports
module reg_file_nr1w
    import rf_pkg::*;
#(
    parameter int   WIDTH    = RF_WIDTH,
    parameter int   DEPTH    = RF_DEPTH,
    parameter int   NRD      = 2,
    parameter int   ZERO_REG = 0,
    localparam int  AW       = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 CLR,
    input  logic                 WE,
    input  logic [AW-1:0]        WADDR,
    input  logic [WIDTH-1:0]     WDATA,
    input  logic [NRD-1:0]       RE,
    input  logic [NRD*AW-1:0]    RADDR,
    output logic [NRD*WIDTH-1:0] RDATA,
    output logic [NRD-1:0]       RVALID
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;

    // Writes to a hardwired-zero register 0 are discarded; clear beats write
    assign wr_en = WE && !CLR && !((ZERO_REG != 0) && (WADDR == '0));

    // Storage: async reset, synchronous bulk clear, single write port
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (CLR) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[WADDR] <= WDATA;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]    raddr_p;
        logic [WIDTH-1:0] mem_rd;

        assign raddr_p = RADDR[p*AW +: AW];
        assign mem_rd  = mem[raddr_p];

        rf_read_port #(
            .WIDTH    (WIDTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .CLK      (CLK),
            .RSTN     (RSTN),
            .CLR      (CLR),
            .WE       (WE),
            .WADDR    (WADDR),
            .WDATA    (WDATA),
            .RE       (RE[p]),
            .RADDR    (raddr_p),
            .MEM_DATA (mem_rd),
            .RDATA    (RDATA[p*WIDTH +: WIDTH]),
            .RVALID   (RVALID[p])
        );
    end

endmodule
